// File: rtl/memory_col_pkg.sv
// Shared constants and FSM state type for the 1024x8 memory column and its request controller.
package memory_col_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = 4;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        RD_BURST = 1'b1
    } state_t;

    // Word address increment; wraps 1023 -> 0 through the natural ADDR_W width.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr);
        return addr + 1'b1;
    endfunction

endpackage

// File: rtl/memory_col_ctrl_if.sv
// Request and response channels between a requester (master) and memory_col_ctrl (slave).
interface memory_col_ctrl_if;
    import memory_col_pkg::*;

    // Both channels use valid/ready: a transfer happens on a rising edge where valid && ready.
    // The source holds its payload stable while valid is high; ready never depends on valid.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [LEN_W-1:0]  req_len;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/memory_col_rsp_fifo.sv
// Synchronous first-word-fall-through response FIFO; dout reads 0 while empty.
module memory_col_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign dout    = empty ? '0 : store_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                store_q[wr_ptr_q] <= din;
                wr_ptr_q          <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/memory_col_ctrl.sv
// Request controller in front of the 1024x8 memory column with credit-protected in-order read returns.
// Define MEMORY_COL_CTRL_BURST_EN to honour req_len and enable incrementing read bursts.
module memory_col_ctrl
    import memory_col_pkg::*;
#(
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    memory_col_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic                mem_byte_en,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                busy,
    output state_t              state
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int CW    = CNT_W + 1;

    state_t            state_q;
    state_t            state_d;
    logic              running_q;
    logic              v_cmd_q;
    logic              v_data_q;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              wr_fire;
    logic              ready;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [CW-1:0]     used;
    logic [CW-1:0]     credit;
    logic              has_credit;

`ifdef MEMORY_COL_CTRL_BURST_EN
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  rem_d;
    logic [ADDR_W-1:0] nxt_q;
    logic [ADDR_W-1:0] nxt_d;
`else
    logic [LEN_W-1:0]  unused_len;
    assign unused_len = bus.req_len;
`endif

    // Beats already in the pipe count against the FIFO so a stalled consumer can never overflow it.
    assign used       = CW'(fifo_count) + CW'(v_cmd_q) + CW'(v_data_q);
    assign credit     = CW'(RSP_DEPTH) - used;
    assign has_credit = (credit != '0);

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = mem_addr;
        wr_fire    = 1'b0;
        ready      = 1'b0;
`ifdef MEMORY_COL_CTRL_BURST_EN
        rem_d      = rem_q;
        nxt_d      = nxt_q;
`endif
        case (state_q)
            IDLE: begin
                ready = running_q && has_credit;
                if (bus.req_valid && ready) begin
                    if (bus.req_we) begin
                        wr_fire = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = bus.req_addr;
`ifdef MEMORY_COL_CTRL_BURST_EN
                        if (bus.req_len != '0) begin
                            state_d = RD_BURST;
                            rem_d   = bus.req_len;
                            nxt_d   = addr_inc(bus.req_addr);
                        end
`endif
                    end
                end
            end
`ifdef MEMORY_COL_CTRL_BURST_EN
            RD_BURST: begin
                if (has_credit) begin
                    issue      = 1'b1;
                    issue_addr = nxt_q;
                    nxt_d      = addr_inc(nxt_q);
                    rem_d      = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            running_q   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_byte_en <= 1'b0;
            v_cmd_q     <= 1'b0;
            v_data_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            running_q   <= 1'b1;
            mem_byte_en <= wr_fire;
            v_cmd_q     <= issue;
            v_data_q    <= v_cmd_q;
            if (wr_fire) begin
                mem_addr    <= bus.req_addr;
                mem_wr_data <= bus.req_wdata;
            end else if (issue) begin
                mem_addr <= issue_addr;
            end
        end
    end

`ifdef MEMORY_COL_CTRL_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            nxt_q <= '0;
        end else begin
            rem_q <= rem_d;
            nxt_q <= nxt_d;
        end
    end
`endif

    memory_col_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (v_data_q),
        .din   (mem_rd_data),
        .pop   (bus.rsp_valid && bus.rsp_ready),
        .dout  (bus.rsp_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign bus.req_ready = ready;
    assign bus.rsp_valid = !fifo_empty;
    assign busy          = (state_q == RD_BURST) || v_cmd_q || v_data_q || !fifo_empty;
    assign state         = state_q;

endmodule

// File: tb/tb_memory_col_ctrl.sv
// Randomized and directed bench for memory_col_ctrl with a behavioural memory column and reference model.
`timescale 1ns/1ps
module tb_memory_col_ctrl;
    import memory_col_pkg::*;

`ifdef MEMORY_COL_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_byte_en;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              busy;
    state_t            dut_state;

    memory_col_ctrl_if bus ();

    memory_col_ctrl #(.RSP_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_byte_en (mem_byte_en),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .state       (dut_state)
    );

    always #5 clk = ~clk;

    // Memory column: registered read of mem_addr, write when the strobe is set.
    logic [DATA_W-1:0] col_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_byte_en) col_mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= col_mem[mem_addr];
    end

    // Reference model: memory contents as seen by the request stream, and expected responses.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q[$];
    int tests = 0;
    int errors = 0;
    int rsp_cnt = 0;
    bit rand_rsp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) begin
                    ref_mem[bus.req_addr] = bus.req_wdata;
                end else begin
                    int beats;
                    beats = BURST ? int'(bus.req_len) + 1 : 1;
                    for (int b = 0; b < beats; b++) begin
                        exp_q.push_back(ref_mem[(int'(bus.req_addr) + b) % DEPTH]);
                    end
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cnt++;
                if (exp_q.size() == 0) check("rsp_unexpected", 32'(bus.rsp_rdata), 32'hFFFF_FFFF);
                else check("rsp_data", 32'(bus.rsp_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rsp) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_req(input logic we, input int addr, input logic [7:0] wd, input int len);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_wdata = wd;
        bus.req_len   = LEN_W'(len);
        while (!bus.req_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.req_ready) check("req_timeout", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 600) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    int beats;
    int start_cnt;
    int seen_valid;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            col_mem[i] = 8'($urandom);
            ref_mem[i] = col_mem[i];
        end
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_len   = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Write 0x5A to 3, then read 3 on the next edge
        send_req(1'b1, 3, 8'h5A, 0);
        check("wr_byte_en", 32'(mem_byte_en), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'd3);
        check("wr_data", 32'(mem_wr_data), 32'h5A);
        send_req(1'b0, 3, 8'h00, 0);
        check("rd_byte_en_low", 32'(mem_byte_en), 32'd0);
        check("rd_addr", 32'(mem_addr), 32'd3);
        check("rd_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("rd_rsp_lat1", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_rsp_data", 32'(bus.rsp_rdata), 32'h5A);
        drain("drain_t1");

        // Back-to-back write 0xC3 to 7 then read 7
        send_req(1'b1, 7, 8'hC3, 0);
        send_req(1'b0, 7, 8'h00, 0);
        tick();
        tick();
        check("b2b_rsp_data", 32'(bus.rsp_rdata), 32'hC3);
        drain("drain_b2b");

        // Burst across the 1023 -> 0 wrap
        send_req(1'b1, 1022, 8'h11, 0);
        send_req(1'b1, 1023, 8'h22, 0);
        send_req(1'b1, 0, 8'h33, 0);
        send_req(1'b1, 1, 8'h44, 0);
        tick();
        beats = BURST ? 4 : 1;
        send_req(1'b0, 1022, 8'h00, 3);
        for (int i = 0; i < 4; i++) begin
            check("wrap_addr", 32'(mem_addr), 32'((1022 + ((i < beats) ? i : beats - 1)) % DEPTH));
            check("wrap_ready", 32'(bus.req_ready), 32'(i >= beats - 1));
            tick();
        end
        drain("drain_wrap");

        // Backpressure: preload 0..7 with their own address, stall the consumer
        for (int i = 0; i < 8; i++) send_req(1'b1, i, 8'(i), 0);
        tick();
        bus.rsp_ready = 1'b0;
        start_cnt = rsp_cnt;
        send_req(1'b0, 0, 8'h00, 7);
        repeat (8) tick();
        beats = BURST ? 8 : 1;
        check("stall_addr", 32'(mem_addr), 32'((beats < 4) ? beats - 1 : 3));
        check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall_rsp_data", 32'(bus.rsp_rdata), 32'd0);
        check("stall_ready", 32'(bus.req_ready), 32'(!BURST));
        bus.rsp_ready = 1'b1;
        drain("drain_stall");
        check("stall_rsp_count", 32'(rsp_cnt - start_cnt), 32'(beats));
        check("stall_last_addr", 32'(mem_addr), 32'(beats - 1));

        // Single-beat read with a nonzero length field
        send_req(1'b0, 10, 8'h00, 5);
        check("len_ready_next", 32'(bus.req_ready), 32'(!BURST));
        start_cnt = rsp_cnt;
        drain("drain_len");
        check("len_rsp_count", 32'(rsp_cnt - start_cnt), 32'(BURST ? 6 : 1));

        // Reset with beats in flight
        send_req(1'b1, 200, 8'h9E, 0);
        send_req(1'b0, 100, 8'h00, 7);
        tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wdata", 32'(mem_wr_data), 32'd0);
        check("mid_rst_byte_en", 32'(mem_byte_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_state", 32'(dut_state), 32'(IDLE));
        repeat (2) tick();
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid) seen_valid++;
        end
        check("post_rst_no_rsp", 32'(seen_valid), 32'd0);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Random traffic with random consumer backpressure
        rand_rsp = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int a;
            a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1016, 1031)) % DEPTH
                                            : int'($urandom_range(0, DEPTH - 1));
            send_req(($urandom_range(0, 2) == 0), a, 8'($urandom), int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_rsp = 1'b0;
        bus.rsp_ready = 1'b1;
        drain("drain_random");
        check("final_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
